alarm_clock_top: RTL and testbench
==================================

Name: alarm_clock_top

Overview:
- 24-hour digital alarm clock core: BCD HH:MM timekeeping, keypad entry of time/alarm digits, alarm compare with sticky alarm output.
- Sits under the front-panel controller. Consumes debounced, single-cycle button/key strobes; drives the sounder and BCD display buses.
- `fastwatch` mode advances one minute per clock cycle for simulation and bring-up.

Parameters:
- CYCLES_PER_SEC, 100_000_000, clock cycles per real-time second (normal mode).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- alarm_button  input  1  one-cycle strobe: load alarm from key buffer, or silence a sounding alarm.
- time_button  input  1  one-cycle strobe: load current time from key buffer.
- key  input  4  keypad digit 0-9; values 10-15 are ignored.
- key_valid  input  1  one-cycle strobe qualifying `key`.
- fastwatch  input  1  1 = advance one minute every clock cycle; 0 = real time.
- sound_alarm  output  1  alarm sounding (sticky).
- cur_time  output  16  current time BCD {H10,H1,M10,M1}.
- alarm_time  output  16  stored alarm BCD {H10,H1,M10,M1}.

Behaviour:
- Reset (reset==0 at a clock edge), all taking effect next cycle:
  - time 00:00:00, alarm 00:00, alarm_armed=0
  - key buffer 0000, prescaler 0, sound_alarm=0
- Key buffer: 4 BCD digits {d3,d2,d1,d0}.
  - On key_valid with key≤9: shift left, buf <= {d2,d1,d0,key}.
  - key>9 is discarded.
  - Keys are not accepted in a cycle where either button is high.
- time_button:
  - If the buffer is a valid time (d3≤2; d3d2≤23; d1≤5): load hours/minutes from it and clear seconds and prescaler.
  - Clear the buffer whether or not the value is valid; invalid values are not loaded.
  - The load overrides any increment in that cycle.
- alarm_button:
  - If sound_alarm=1: clear sound_alarm only; no load, buffer untouched.
  - Otherwise, same validity rule as time_button. A valid value loads alarm_time and sets alarm_armed=1; the buffer is cleared either way.
- Both buttons in the same cycle: time_button acts, alarm_button is ignored.
- All loads are visible on the outputs the cycle after the strobe edge.
- Timekeeping, fastwatch=1: minute increments every cycle (seconds held at 0).
- Timekeeping, fastwatch=0:
  - Prescaler counts 0..CYCLES_PER_SEC-1.
  - On terminal count, seconds increment 0..59; on 59 wrap to 0 and increment minute.
- BCD carries:
  - M1 9→0 carries to M10; M10 5→0 carries to hour.
  - Hour 09→10, 19→20, 23→00.
  - 23:59 wraps to 00:00.
- Alarm compare:
  - Registered each cycle: if alarm_armed and cur_time==alarm_time, set sound_alarm on the next edge.
  - sound_alarm stays 1 (even after the time moves on) until alarm_button or reset.
  - Compare runs on register contents, so a time load equal to the armed alarm raises sound_alarm one cycle after the load is visible.
- Reset mid-operation: reset dominates all buttons, keys and counting in the same cycle.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 two cycles, release, fastwatch=0.
  - Required: cur_time=0x0000, alarm_time=0x0000, sound_alarm=0.
  - Required: cur_time stays 0x0000 for fewer than CYCLES_PER_SEC*60 cycles.
- Time load and wrap:
  - Stimulus: fastwatch=0; keys 2,3,5,9; time_button.
  - Required: cur_time=0x2359 next cycle.
  - Stimulus: then fastwatch=1 for one cycle.
  - Required: cur_time=0x0000.
- Invalid entry:
  - Stimulus: keys 2,4,0,0 then time_button.
  - Required: cur_time unchanged; buffer cleared.
  - Stimulus: keys 1,2,6,0 then alarm_button.
  - Required: alarm_time unchanged, alarm not armed.
  - Stimulus: key=4'hA strobe.
  - Required: buffer unchanged.
- Alarm fire:
  - Stimulus: fastwatch=0; load time 23:58; load alarm 23:59; set fastwatch=1.
  - Required: cur_time 0x2359 then 0x0000.
  - Required: sound_alarm=1 starting the cycle after cur_time==0x2359, held while time continues.
- Silence:
  - Stimulus: alarm_button while sound_alarm=1.
  - Required: sound_alarm=0 next cycle; alarm_time still 0x2359.
  - Required: re-fires when cur_time next reaches 0x2359 (1440 cycles later in fastwatch).
- Priority/reset:
  - Stimulus: time_button and alarm_button same cycle with buffer 0x1230.
  - Required: cur_time=0x1230; alarm_time unchanged.
  - Stimulus: reset=0 while sound_alarm=1.
  - Required: sound_alarm=0 and alarm disarmed.

Source files
------------

// File: rtl/alarm_clock_top.sv
// 24-hour BCD alarm clock core: keypad digit buffer, HH:MM:SS timekeeping
// with a fast-forward mode, and a sticky alarm that a button press silences.
module alarm_clock_top #(
    parameter int CYCLES_PER_SEC = 100_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alarm_button,
    input  logic        time_button,
    input  logic [3:0]  key,
    input  logic        key_valid,
    input  logic        fastwatch,
    output logic        sound_alarm,
    output logic [15:0] cur_time,
    output logic [15:0] alarm_time
);

    localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CYCLES_PER_SEC - 1);

    logic [15:0]   time_q;
    logic [15:0]   alarm_q;
    logic [15:0]   key_buf;
    logic [5:0]    sec_q;
    logic [PW-1:0] pre_q;
    logic          armed_q;
    logic          sound_q;

    // A buffer value is a legal HH:MM when hours are 00-23 and M10 is 0-5.
    function automatic logic valid_hhmm(input logic [15:0] v);
        logic hours_ok;
        hours_ok = (v[15:12] < 4'd2) || (v[15:12] == 4'd2 && v[11:8] <= 4'd3);
        return hours_ok && (v[7:4] <= 4'd5);
    endfunction

    function automatic logic [15:0] next_minute(input logic [15:0] t);
        logic [3:0] h10, h1, m10, m1;
        // NOTE: blocking assignments are correct here; these are function
        // locals evaluated in order, not clocked state.
        {h10, h1, m10, m1} = t;
        if (m1 != 4'd9) begin
            m1 = m1 + 4'd1;
        end else begin
            m1 = 4'd0;
            if (m10 != 4'd5) begin
                m10 = m10 + 4'd1;
            end else begin
                m10 = 4'd0;
                if (h10 == 4'd2 && h1 == 4'd3) begin
                    h10 = 4'd0;
                    h1  = 4'd0;
                end else if (h1 == 4'd9) begin
                    h1  = 4'd0;
                    h10 = h10 + 4'd1;
                end else begin
                    h1 = h1 + 4'd1;
                end
            end
        end
        return {h10, h1, m10, m1};
    endfunction

    logic key_accept;
    logic alarm_cmd;
    logic silence;
    logic time_load;
    logic alarm_load;
    logic buf_clear;
    logic sec_tick;
    logic buf_valid;

    // time_button wins over alarm_button; keys are dropped while any button is high.
    assign buf_valid  = valid_hhmm(key_buf);
    assign key_accept = key_valid && (key <= 4'd9) && !time_button && !alarm_button;
    assign alarm_cmd  = alarm_button && !time_button;
    assign silence    = alarm_cmd && sound_q;
    assign time_load  = time_button && buf_valid;
    assign alarm_load = alarm_cmd && !sound_q && buf_valid;
    assign buf_clear  = time_button || (alarm_cmd && !sound_q);
    assign sec_tick   = (pre_q == PRE_LAST);

    // NOTE: reset is synchronous and active-low, so it is tested inside the
    // clocked block and takes priority over every other update that cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            time_q  <= '0;
            alarm_q <= '0;
            key_buf <= '0;
            sec_q   <= '0;
            pre_q   <= '0;
            armed_q <= 1'b0;
            sound_q <= 1'b0;
        end else begin
            if (key_accept) begin
                key_buf <= {key_buf[11:0], key};
            end else if (buf_clear) begin
                key_buf <= '0;
            end

            if (time_load) begin
                time_q <= key_buf;
                sec_q  <= '0;
                pre_q  <= '0;
            end else if (fastwatch) begin
                time_q <= next_minute(time_q);
                sec_q  <= '0;
                pre_q  <= '0;
            end else if (sec_tick) begin
                pre_q <= '0;
                if (sec_q == 6'd59) begin
                    sec_q  <= '0;
                    time_q <= next_minute(time_q);
                end else begin
                    sec_q <= sec_q + 6'd1;
                end
            end else begin
                pre_q <= pre_q + PW'(1);
            end

            if (alarm_load) begin
                alarm_q <= key_buf;
                armed_q <= 1'b1;
            end

            // Compare uses registered values, so it lags any load by one cycle.
            if (silence) begin
                sound_q <= 1'b0;
            end else if (armed_q && (time_q == alarm_q)) begin
                sound_q <= 1'b1;
            end
        end
    end

    assign sound_alarm = sound_q;
    assign cur_time    = time_q;
    assign alarm_time  = alarm_q;

endmodule

// File: tb/tb_alarm_clock_top.sv
// Directed bench for alarm_clock_top: reset, keypad loads, BCD wrap,
// invalid entries, alarm fire/silence/refire, button priority and reset.
module tb_alarm_clock_top;

    localparam int CPS = 4;

    logic        clock;
    logic        reset;
    logic        alarm_button;
    logic        time_button;
    logic [3:0]  key;
    logic        key_valid;
    logic        fastwatch;
    logic        sound_alarm;
    logic [15:0] cur_time;
    logic [15:0] alarm_time;

    int errors = 0;
    int checks = 0;

    alarm_clock_top #(.CYCLES_PER_SEC(CPS)) dut (
        .clock        (clock),
        .reset        (reset),
        .alarm_button (alarm_button),
        .time_button  (time_button),
        .key          (key),
        .key_valid    (key_valid),
        .fastwatch    (fastwatch),
        .sound_alarm  (sound_alarm),
        .cur_time     (cur_time),
        .alarm_time   (alarm_time)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Outputs are sampled and inputs changed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press_key(input logic [3:0] k);
        key       = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        key       = 4'd0;
    endtask

    task automatic press_time();
        time_button = 1'b1;
        tick();
        time_button = 1'b0;
    endtask

    task automatic press_alarm();
        alarm_button = 1'b1;
        tick();
        alarm_button = 1'b0;
    endtask

    logic stay_ok;
    logic fired;
    int   n;

    initial begin
        reset        = 1'b0;
        alarm_button = 1'b0;
        time_button  = 1'b0;
        key          = 4'd0;
        key_valid    = 1'b0;
        fastwatch    = 1'b0;

        // Reset held two edges
        tick();
        tick();
        check("rst_cur", cur_time, 16'h0000);
        check("rst_alarm", alarm_time, 16'h0000);
        check("rst_sound", {15'b0, sound_alarm}, 16'd0);
        reset = 1'b1;

        // With CPS=4 the first minute lands on the 240th edge after release
        stay_ok = 1'b1;
        for (int i = 1; i <= 239; i++) begin
            tick();
            if (cur_time !== 16'h0000) stay_ok = 1'b0;
        end
        check("hold_zero", {15'b0, stay_ok}, 16'd1);
        tick();
        check("first_minute", cur_time, 16'h0001);

        // Time load and midnight wrap
        press_key(4'd2); press_key(4'd3); press_key(4'd5); press_key(4'd9);
        press_time();
        check("load_2359", cur_time, 16'h2359);
        fastwatch = 1'b1;
        tick();
        fastwatch = 1'b0;
        check("wrap_0000", cur_time, 16'h0000);

        // Invalid time entry, then buffer-cleared probe
        press_key(4'd2); press_key(4'd4); press_key(4'd0); press_key(4'd0);
        press_time();
        check("inv_time", cur_time, 16'h0000);
        press_key(4'd1);
        press_time();
        check("buf_cleared", cur_time, 16'h0001);

        // Invalid alarm entry: no load, not armed, buffer cleared
        press_key(4'd1); press_key(4'd2); press_key(4'd6); press_key(4'd0);
        press_alarm();
        check("inv_alarm", alarm_time, 16'h0000);
        press_time();
        check("alarm_buf_cleared", cur_time, 16'h0000);
        tick();
        tick();
        check("not_armed", {15'b0, sound_alarm}, 16'd0);

        // Out-of-range key discarded
        press_key(4'd1); press_key(4'd2); press_key(4'hA); press_key(4'd3); press_key(4'd4);
        press_time();
        check("key_a_ignored", cur_time, 16'h1234);

        // Key coincident with a button is dropped
        press_key(4'd1); press_key(4'd1); press_key(4'd5);
        key         = 4'd7;
        key_valid   = 1'b1;
        time_button = 1'b1;
        tick();
        key_valid   = 1'b0;
        time_button = 1'b0;
        check("load_0115", cur_time, 16'h0115);
        press_time();
        check("key_blocked", cur_time, 16'h0000);

        // Alarm fire
        press_key(4'd2); press_key(4'd3); press_key(4'd5); press_key(4'd8);
        press_time();
        check("load_2358", cur_time, 16'h2358);
        press_key(4'd2); press_key(4'd3); press_key(4'd5); press_key(4'd9);
        press_alarm();
        check("alarm_2359", alarm_time, 16'h2359);
        check("quiet_before", {15'b0, sound_alarm}, 16'd0);
        fastwatch = 1'b1;
        tick();
        check("fw_2359", cur_time, 16'h2359);
        check("not_yet", {15'b0, sound_alarm}, 16'd0);
        tick();
        check("fw_0000", cur_time, 16'h0000);
        check("fire", {15'b0, sound_alarm}, 16'd1);
        tick();
        check("fw_0001", cur_time, 16'h0001);
        check("sticky", {15'b0, sound_alarm}, 16'd1);

        // Silence, then refire one day later
        press_alarm();
        check("silenced", {15'b0, sound_alarm}, 16'd0);
        check("alarm_kept", alarm_time, 16'h2359);
        check("fw_0002", cur_time, 16'h0002);
        fired = 1'b0;
        n     = 0;
        for (int i = 0; i < 2000 && !fired; i++) begin
            tick();
            n++;
            if (sound_alarm === 1'b1) fired = 1'b1;
        end
        check("refire_cycles", 16'(n), 16'd1438);
        check("refire_cur", cur_time, 16'h0000);
        fastwatch = 1'b0;

        // Both buttons together: time wins, alarm ignored, still sounding
        press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd0);
        time_button  = 1'b1;
        alarm_button = 1'b1;
        tick();
        time_button  = 1'b0;
        alarm_button = 1'b0;
        check("prio_cur", cur_time, 16'h1230);
        check("prio_alarm", alarm_time, 16'h2359);
        check("prio_sound", {15'b0, sound_alarm}, 16'd1);

        // Reset while sounding dominates buttons and keys
        reset        = 1'b0;
        alarm_button = 1'b1;
        key          = 4'd5;
        key_valid    = 1'b1;
        tick();
        reset        = 1'b1;
        alarm_button = 1'b0;
        key_valid    = 1'b0;
        key          = 4'd0;
        check("rst2_sound", {15'b0, sound_alarm}, 16'd0);
        check("rst2_cur", cur_time, 16'h0000);
        check("rst2_alarm", alarm_time, 16'h0000);
        tick();
        tick();
        check("disarmed", {15'b0, sound_alarm}, 16'd0);
        press_time();
        check("rst2_buf", cur_time, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
